fir_out_decim: RTL
==================

FIR_OUT_DECIM -- requirements
Module: fir_out_decim

Interface
- REQ-001: Parameter W, default 12, sample width in bits; matches FIR output width.
- REQ-002: Parameter DEPTH, default 8, output FIFO depth in samples; power of two, 2..16.
- REQ-003: Port Clk, input, 1, single clock; all state on rising edge.
- REQ-004: Port Hlt, input, 1, reset; asynchronous, active-high.
- REQ-005: Port Din, input, W, FIR output sample, two's complement.
- REQ-006: Port din_valid, input, 1, Din holds a new sample this cycle.
- REQ-007: Port decim, input, 4, decimation ratio minus one; ratio = decim+1 (1..16).
- REQ-008: Port Dout, output, W, head-of-FIFO sample (first-word fall-through).
- REQ-009: Port dout_valid, output, 1, FIFO non-empty.
- REQ-010: Port dout_ready, input, 1, consumer accepts Dout this cycle.
- REQ-011: Port fill, output, 5, current FIFO occupancy, 0..DEPTH.
- REQ-012: Port overflow, output, 1, sticky: a kept sample was dropped because FIFO was full.
- REQ-013: Port clr_ovf, input, 1, synchronous clear of overflow.

Function
- REQ-014: Phase counter (4 bits) advances only on cycles with din_valid=1; cycles with din_valid=0 change no state except FIFO pops.
- REQ-015: On din_valid=1: sample is "kept" iff phase==0; next phase = 0 if phase>=decim, else phase+1.
- REQ-016: decim=0 keeps every valid sample; decim=3 keeps samples 0,4,8,... of the valid stream.
- REQ-017: decim change mid-stream takes effect immediately via the >= compare; no out-of-range phase persists beyond one valid sample.
- REQ-018: Pop occurs when dout_valid=1 and dout_ready=1; push occurs when a kept sample arrives and (fill<DEPTH or pop in same cycle).
- REQ-019: Simultaneous push and pop at any fill: fill unchanged, order preserved.
- REQ-020: Push when fill==DEPTH with no pop: sample dropped, FIFO unchanged, overflow set next cycle.
- REQ-021: Pop when empty is ignored; dout_ready has no effect while dout_valid=0.
- REQ-022: Latency: kept sample on Din at edge N appears on Dout with dout_valid=1 after edge N when FIFO was empty (one cycle).
- REQ-023: Dout shall read 0 while fill==0; Dout shall be stable while dout_valid=1 and dout_ready=0.
- REQ-024: Read/write pointers wrap modulo DEPTH; fill distinguishes full from empty.
- REQ-025: clr_ovf=1 clears overflow next cycle; a drop in the same cycle wins (overflow stays 1).
- REQ-026: Data passes bit-exact; no arithmetic, rounding or sign change on samples.

Reset
- REQ-027: Hlt=1 asynchronously forces phase=0, pointers=0, fill=0, dout_valid=0, Dout=0, overflow=0.
- REQ-028: Hlt asserted mid-operation discards all buffered samples; first valid sample after release is phase 0 and kept.
- REQ-029: No push or pop occurs on any edge while Hlt=1.

Verification
- REQ-030: decim=0, dout_ready=1, Din=1,2,3 valid consecutively -> Dout 1,2,3 with dout_valid, each one cycle after input, fill<=1.
- REQ-031: decim=3, Din=0..11 valid every cycle, dout_ready=1 -> output sequence 0,4,8 only.
- REQ-032: decim=0, dout_ready=0, 10 valid samples 100..109 -> fill=8, overflow=1, then drain yields 100..107 in order.
- REQ-033: fill=8, simultaneous kept push 55 and pop -> fill stays 8, overflow stays 0, 55 emerges last.
- REQ-034: overflow=1, clr_ovf=1 with no drop -> overflow=0 next cycle; clr_ovf with concurrent drop -> overflow remains 1.
- REQ-035: decim=2, Hlt pulsed after 4 samples with fill=2 -> all outputs 0, fill=0; next valid Din=-5 (0xFFB) emerges as 0xFFB.

Source files
------------

// File: rtl/fir_out_decim_if.sv
// ============================================================================
// Module  : fir_out_decim_if
// Brief   : Sample-in / FIFO-out bundle for the FIR output decimator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface fir_out_decim_if #(
  parameter int W = 12
);
  logic [W-1:0] Din;
  logic         din_valid;
  logic [3:0]   decim;
  logic [W-1:0] Dout;
  logic         dout_valid;
  logic         dout_ready;
  logic [4:0]   fill;
  logic         overflow;
  logic         clr_ovf;

  modport master (
    output Din, din_valid, decim, dout_ready, clr_ovf,
    input  Dout, dout_valid, fill, overflow
  );

  modport slave (
    input  Din, din_valid, decim, dout_ready, clr_ovf,
    output Dout, dout_valid, fill, overflow
  );
endinterface

`default_nettype wire

// File: rtl/fir_out_decim.sv
// ============================================================================
// Module  : fir_out_decim
// Brief   : Decimates a FIR sample stream and buffers kept samples in a FWFT FIFO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_out_decim #(
  parameter int W     = 12,
  parameter int DEPTH = 8
) (
  input  logic             Clk,
  input  logic             Hlt,
  fir_out_decim_if.slave   bus
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] c_DEPTH = 5'(DEPTH);

  logic [3:0]    phase_q, phase_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [4:0]    fill_q, fill_d;
  logic          ovf_q, ovf_d;
  logic [W-1:0]  mem_q [DEPTH];

  logic w_keep, w_pop, w_push, w_drop;

  always_comb begin
    w_keep = bus.din_valid && (phase_q == 4'd0);
    w_pop  = (fill_q != 5'd0) && bus.dout_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    w_push = w_keep && ((fill_q != c_DEPTH) || w_pop);
    w_drop = w_keep && !w_push;

    phase_d = phase_q;
    if (bus.din_valid) begin
      phase_d = (phase_q >= bus.decim) ? 4'd0 : phase_q + 4'd1;
    end

    wr_d = w_push ? wr_q + AW'(1) : wr_q;
    rd_d = w_pop  ? rd_q + AW'(1) : rd_q;

    fill_d = fill_q;
    case ({w_push, w_pop})
      2'b10:   fill_d = fill_q + 5'd1;
      2'b01:   fill_d = fill_q - 5'd1;
      default: fill_d = fill_q;
    endcase

    // A drop outranks a concurrent clear so no lost sample goes unreported.
    ovf_d = w_drop ? 1'b1 : (bus.clr_ovf ? 1'b0 : ovf_q);
  end

  always_ff @(posedge Clk or posedge Hlt) begin
    if (Hlt) begin
      phase_q <= 4'd0;
      wr_q    <= '0;
      rd_q    <= '0;
      fill_q  <= 5'd0;
      ovf_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      fill_q  <= fill_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (w_push && !Hlt) begin
      mem_q[wr_q] <= bus.Din;
    end
  end

  assign bus.Dout       = (fill_q != 5'd0) ? mem_q[rd_q] : '0;
  assign bus.dout_valid = (fill_q != 5'd0);
  assign bus.fill       = fill_q;
  assign bus.overflow   = ovf_q;

endmodule

`default_nettype wire
